// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the instruction-fetch
// port and the MEM-stage data port. Data normally wins, but fetch is forced through
// after FAIR_LIMIT consecutive data grants made while fetch was waiting.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a BUSY phase that
// reaches TIMEOUT_CYC cycles without MRDY is abandoned and ERR is pulsed.
module mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int FAIR_LIMIT  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rstn,
    // instruction-fetch port (read only)
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] irdata,
    output logic          irdy,
    // MEM-stage data port
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic [DW-1:0] drdata,
    output logic          drdy,
    // unified memory
    output logic          mreq,
    output logic          mwe,
    output logic [AW-1:0] maddr,
    output logic [DW-1:0] mwdata,
    input  logic [DW-1:0] mrdata,
    input  logic          mrdy,
    // pipeline stalls and timeout flag
    output logic          istall,
    output logic          dstall,
    output logic          err
);

    localparam int DCW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
    localparam logic [DCW-1:0] DCNT_MAX = DCW'(FAIR_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DCW-1:0] dcnt;
    logic           mwe_q;
    logic           gnt_data;
    logic           busy;
    logic           fetch_sel;
    logic           grant_i;
    logic           grant_d;
    logic           complete;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tocnt;
    logic       timeout;
    logic       err_q;
`endif

    assign busy      = (state == IBUSY) || (state == DBUSY);
    assign mreq      = busy;
    assign mwe       = busy & mwe_q;
    assign fetch_sel = ireq & (~dreq | (dcnt == DCNT_MAX));
    assign istall    = ireq & ~irdy;
    assign dstall    = dreq & ~drdy;

    // Next-state decode: arbitration in IDLE, wait for memory in BUSY, one-cycle DONE
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        complete  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fetch_sel) begin
                    state_nxt = IBUSY;
                    grant_i   = 1'b1;
                end else if (dreq) begin
                    state_nxt = DBUSY;
                    grant_d   = 1'b1;
                end
            end
            IBUSY, DBUSY: begin
                if (mrdy) begin
                    state_nxt = DONE;
                    complete  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (tocnt == TO_LAST) begin
                    state_nxt = DONE;
                    timeout   = 1'b1;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the granted request's operands so the memory sees them stable through BUSY
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            maddr    <= '0;
            mwdata   <= '0;
            mwe_q    <= 1'b0;
            gnt_data <= 1'b0;
        end else if (grant_i) begin
            maddr    <= iaddr;
            mwe_q    <= 1'b0;
            gnt_data <= 1'b0;
        end else if (grant_d) begin
            maddr    <= daddr;
            mwdata   <= dwdata;
            mwe_q    <= dwe;
            gnt_data <= 1'b1;
        end
    end

    // Return data to the granted port and raise its ready for the single DONE cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irdata <= '0;
            drdata <= '0;
            irdy   <= 1'b0;
            drdy   <= 1'b0;
        end else begin
            irdy <= 1'b0;
            drdy <= 1'b0;
            if (complete) begin
                if (gnt_data) begin
                    drdy <= 1'b1;
                    if (!mwe_q) begin
                        drdata <= mrdata;
                    end
                end else begin
                    irdy   <= 1'b1;
                    irdata <= mrdata;
                end
            end
`ifdef ARB_TIMEOUT_EN
            if (timeout) begin
                if (gnt_data) begin
                    drdy   <= 1'b1;
                    drdata <= '0;
                end else begin
                    irdy   <= 1'b1;
                    irdata <= '0;
                end
            end
`endif
        end
    end

    // Count data grants that overtook a waiting fetch; a fetch grant clears the count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
        end else if (grant_i) begin
            dcnt <= '0;
        end else if (grant_d && ireq && (dcnt != DCNT_MAX)) begin
            dcnt <= dcnt + 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Count stalled BUSY cycles and flag the cycle in which an access is abandoned
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tocnt <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (grant_i || grant_d) begin
                tocnt <= '0;
            end else if (busy && !mrdy) begin
                tocnt <= tocnt + 8'd1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (shadow memory, fairness streak, request/ack timing).
module tb_mem_arbiter;

    localparam int AW          = 32;
    localparam int DW          = 32;
    localparam int FAIR_LIMIT  = 4;
    localparam int TIMEOUT_CYC = 255;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] irdata;
    logic          irdy;
    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          drdy;
    logic          mreq;
    logic          mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrdata;
    logic          mrdy;
    logic          istall;
    logic          dstall;
    logic          err;

    int total = 0;
    int bad   = 0;

    logic [31:0] shadow [logic [31:0]];
    logic [31:0] rmem   [logic [31:0]];
    logic [31:0] exp_irdata;
    logic [31:0] exp_drdata;
    int          streak;

    mem_arbiter #(
        .AW(AW), .DW(DW), .FAIR_LIMIT(FAIR_LIMIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .irdy(irdy),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .drdy(drdy),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
        .mrdata(mrdata), .mrdy(mrdy),
        .istall(istall), .dstall(dstall), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [31:0] a);
        if (rmem.exists(a)) return rmem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h100 + ($urandom_range(0, 7) << 2);
    endfunction

    task automatic do_reset();
        rstn   = 1'b0;
        ireq   = 1'b0;
        iaddr  = '0;
        dreq   = 1'b0;
        dwe    = 1'b0;
        daddr  = '0;
        dwdata = '0;
        mrdy   = 1'b0;
        mrdata = '0;
        repeat (2) @(negedge clk);
        rstn       = 1'b1;
        exp_irdata = '0;
        exp_drdata = '0;
        streak     = 0;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        ireq   = 1'b1;
        iaddr  = 32'h40;
        dreq   = 1'b1;
        dwe    = 1'b1;
        daddr  = 32'h100;
        dwdata = 32'h55;
        mrdy   = 1'b1;
        mrdata = 32'h12345678;
        repeat (2) @(negedge clk);
        total++;
        if ({mreq, mwe, irdy, drdy, err} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b want 00000", {mreq, mwe, irdy, drdy, err});
        end
        total++;
        if ({maddr, mwdata, irdata, drdata} !== 128'b0) begin
            bad++;
            $display("[TB] FAIL reset_data: got %h want 0", {maddr, mwdata, irdata, drdata});
        end
        total++;
        if ({istall, dstall} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL reset_stall: got %b want 11", {istall, dstall});
        end
        do_reset();
    endtask

    task automatic test_fetch();
        do_reset();
        ireq  = 1'b1;
        iaddr = 32'h40;
        #1;
        total++;
        if (istall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fetch_stall0: got %b want 1", istall);
        end
        @(negedge clk);
        total++;
        if ({mreq, mwe, irdy, istall} !== 4'b1001 || maddr !== 32'h40) begin
            bad++;
            $display("[TB] FAIL fetch_busy: got %b/%h want 1001/00000040", {mreq, mwe, irdy, istall}, maddr);
        end
        mrdy   = 1'b1;
        mrdata = 32'h8C220004;
        @(negedge clk);
        total++;
        if ({mreq, irdy, istall} !== 3'b010 || irdata !== 32'h8C220004) begin
            bad++;
            $display("[TB] FAIL fetch_done: got %b/%h want 010/8c220004", {mreq, irdy, istall}, irdata);
        end
        ireq = 1'b0;
        mrdy = 1'b0;
        @(negedge clk);
        total++;
        if ({mreq, irdy} !== 2'b00 || irdata !== 32'h8C220004) begin
            bad++;
            $display("[TB] FAIL fetch_hold: got %b/%h want 00/8c220004", {mreq, irdy}, irdata);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        ireq   = 1'b1;
        iaddr  = 32'h80;
        dreq   = 1'b1;
        dwe    = 1'b1;
        daddr  = 32'h100;
        dwdata = 32'h55;
        @(negedge clk);
        total++;
        if ({mreq, mwe, istall, dstall} !== 4'b1111 || maddr !== 32'h100 || mwdata !== 32'h55) begin
            bad++;
            $display("[TB] FAIL simul_write: got %b/%h/%h want 1111/00000100/00000055",
                     {mreq, mwe, istall, dstall}, maddr, mwdata);
        end
        mrdy   = 1'b1;
        mrdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({mreq, irdy, drdy} !== 3'b001 || drdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL simul_wdone: got %b/%h want 001/00000000", {mreq, irdy, drdy}, drdata);
        end
        dreq = 1'b0;
        mrdy = 1'b0;
        @(negedge clk);
        total++;
        if ({mreq, irdy, drdy} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL simul_idle: got %b want 000", {mreq, irdy, drdy});
        end
        @(negedge clk);
        total++;
        if ({mreq, mwe} !== 2'b10 || maddr !== 32'h80) begin
            bad++;
            $display("[TB] FAIL simul_fetch: got %b/%h want 10/00000080", {mreq, mwe}, maddr);
        end
        mrdy   = 1'b1;
        mrdata = 32'h1234;
        @(negedge clk);
        total++;
        if (irdy !== 1'b1 || irdata !== 32'h1234) begin
            bad++;
            $display("[TB] FAIL simul_fdone: got %b/%h want 1/00001234", irdy, irdata);
        end
        ireq = 1'b0;
        mrdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starvation();
        logic grants[$];
        logic want;
        do_reset();
        ireq   = 1'b1;
        iaddr  = 32'h40;
        dreq   = 1'b1;
        dwe    = 1'b1;
        daddr  = 32'h100;
        dwdata = 32'h77;
        mrdy   = 1'b1;
        mrdata = 32'h0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mreq) grants.push_back(mwe);
        end
        total++;
        if (grants.size() < 10) begin
            bad++;
            $display("[TB] FAIL starve_count: got %0d want >=10", grants.size());
        end
        for (int k = 0; k < 10 && k < grants.size(); k++) begin
            want = (k % 5 == 4) ? 1'b0 : 1'b1;
            total++;
            if (grants[k] !== want) begin
                bad++;
                $display("[TB] FAIL starve_grant%0d: got mwe=%b want mwe=%b", k, grants[k], want);
            end
        end
        do_reset();
    endtask

    task automatic test_traffic(input int ncyc, input int ipct, input int dpct, input int mpct);
        int          phase;
        int          port;
        logic [31:0] t_addr;
        logic [31:0] t_wdata;
        logic        t_we;
        logic        i_act;
        logic        d_act;
        logic        fsel;
        logic        e_irdy;
        logic        e_drdy;
        do_reset();
        phase   = 0;
        port    = 0;
        t_addr  = '0;
        t_wdata = '0;
        t_we    = 1'b0;
        i_act   = 1'b0;
        d_act   = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            // model: 0 = arbiter free, 1 = access in flight, 2 = acknowledge cycle
            case (phase)
                0: begin
                    if (ireq || dreq) begin
                        fsel = ireq && (!dreq || streak == FAIR_LIMIT);
                        if (fsel) begin
                            port    = 1;
                            streak  = 0;
                            t_addr  = iaddr;
                            t_we    = 1'b0;
                            t_wdata = '0;
                        end else begin
                            port = 2;
                            if (ireq && streak < FAIR_LIMIT) streak++;
                            t_addr  = daddr;
                            t_we    = dwe;
                            t_wdata = dwdata;
                        end
                        phase = 1;
                    end
                end
                1: begin
                    if (mrdy) begin
                        phase = 2;
                        if (port == 1) exp_irdata = shadow_rd(t_addr);
                        else if (t_we) shadow[t_addr] = t_wdata;
                        else exp_drdata = shadow_rd(t_addr);
                    end
                end
                default: begin
                    phase = 0;
                    port  = 0;
                end
            endcase
            e_irdy = (phase == 2) && (port == 1);
            e_drdy = (phase == 2) && (port == 2);
            total++;
            if (mreq !== (phase == 1)) begin
                bad++;
                $display("[TB] FAIL rnd_mreq c%0d: got %b want %b", c, mreq, phase == 1);
            end
            if (phase == 1) begin
                total++;
                if (maddr !== t_addr || mwe !== t_we || (t_we && mwdata !== t_wdata)) begin
                    bad++;
                    $display("[TB] FAIL rnd_op c%0d: got %h/%b/%h want %h/%b/%h",
                             c, maddr, mwe, mwdata, t_addr, t_we, t_wdata);
                end
            end
            total++;
            if ({irdy, drdy, err} !== {e_irdy, e_drdy, 1'b0}) begin
                bad++;
                $display("[TB] FAIL rnd_rdy c%0d: got %b want %b", c, {irdy, drdy, err}, {e_irdy, e_drdy, 1'b0});
            end
            total++;
            if (irdata !== exp_irdata || drdata !== exp_drdata) begin
                bad++;
                $display("[TB] FAIL rnd_rdata c%0d: got %h/%h want %h/%h", c, irdata, drdata, exp_irdata, exp_drdata);
            end
            total++;
            if ({istall, dstall} !== {ireq & ~e_irdy, dreq & ~e_drdy}) begin
                bad++;
                $display("[TB] FAIL rnd_stall c%0d: got %b want %b", c, {istall, dstall}, {ireq & ~e_irdy, dreq & ~e_drdy});
            end
            // requesters: drop on ready, then maybe issue a new request
            if (irdy) begin
                i_act = 1'b0;
                ireq  = 1'b0;
            end
            if (drdy) begin
                d_act = 1'b0;
                dreq  = 1'b0;
            end
            if (!i_act && $urandom_range(0, 99) < ipct) begin
                i_act = 1'b1;
                ireq  = 1'b1;
                iaddr = rand_addr();
            end
            if (!d_act && $urandom_range(0, 99) < dpct) begin
                d_act  = 1'b1;
                dreq   = 1'b1;
                daddr  = rand_addr();
                dwe    = 1'($urandom_range(0, 1));
                dwdata = $urandom;
            end
            // memory responder: random wait states, junk handshakes while not requested
            if (mreq) begin
                mrdy = ($urandom_range(0, 99) < mpct);
                if (mrdy && mwe) begin
                    rmem[maddr] = mwdata;
                    mrdata = $urandom;
                end else if (mrdy) begin
                    mrdata = rmem_rd(maddr);
                end else begin
                    mrdata = $urandom;
                end
            end else begin
                mrdy   = 1'($urandom_range(0, 1));
                mrdata = $urandom;
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dreq  = 1'b1;
        dwe   = 1'b0;
        daddr = 32'h200;
        @(negedge clk);
        total++;
        if (mreq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_busy: got %b want 1", mreq);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (mreq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_async: got %b want 0", mreq);
        end
        @(negedge clk);
        dreq   = 1'b0;
        mrdy   = 1'b1;
        mrdata = 32'hFFFF0000;
        rstn   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({mreq, irdy, drdy} !== 3'b000 || drdata !== 32'h0) begin
                bad++;
                $display("[TB] FAIL rstmid_quiet%0d: got %b/%h want 000/00000000", c, {mreq, irdy, drdy}, drdata);
            end
        end
        mrdy  = 1'b0;
        ireq  = 1'b1;
        iaddr = 32'h44;
        @(negedge clk);
        total++;
        if (mreq !== 1'b1 || maddr !== 32'h44) begin
            bad++;
            $display("[TB] FAIL rstmid_idle: got %b/%h want 1/00000044", mreq, maddr);
        end
        mrdy   = 1'b1;
        mrdata = 32'h1111;
        @(negedge clk);
        total++;
        if (irdy !== 1'b1 || irdata !== 32'h1111) begin
            bad++;
            $display("[TB] FAIL rstmid_fetch: got %b/%h want 1/00001111", irdy, irdata);
        end
        ireq = 1'b0;
        mrdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int busy_n;
        int errs;
        logic seen_end;
        do_reset();
        ireq  = 1'b1;
        iaddr = 32'h300;
        @(negedge clk);
        mrdy   = 1'b1;
        mrdata = 32'hAAAA5555;
        @(negedge clk);
        total++;
        if (irdata !== 32'hAAAA5555) begin
            bad++;
            $display("[TB] FAIL tmo_pre: got %h want aaaa5555", irdata);
        end
        ireq = 1'b0;
        mrdy = 1'b0;
        @(negedge clk);
        ireq     = 1'b1;
        iaddr    = 32'h304;
        busy_n   = 0;
        errs     = 0;
        seen_end = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 400 && !seen_end; c++) begin
            @(negedge clk);
            if (mreq) busy_n++;
            else if (busy_n > 0) seen_end = 1'b1;
        end
        total++;
        if (seen_end !== 1'b1 || busy_n != TIMEOUT_CYC) begin
            bad++;
            $display("[TB] FAIL tmo_len: got end=%b busy=%0d want end=1 busy=%0d", seen_end, busy_n, TIMEOUT_CYC);
        end
        total++;
        if ({irdy, err} !== 2'b11 || irdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL tmo_pulse: got %b/%h want 11/00000000", {irdy, err}, irdata);
        end
        ireq = 1'b0;
        @(negedge clk);
        total++;
        if ({irdy, err, mreq} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL tmo_after: got %b want 000", {irdy, err, mreq});
        end
`else
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (mreq) busy_n++;
            if (err || irdy) errs++;
        end
        total++;
        if (busy_n != 1000) begin
            bad++;
            $display("[TB] FAIL tmo_wait: got %0d busy cycles want 1000", busy_n);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("[TB] FAIL tmo_noerr: got %0d err/irdy cycles want 0", errs);
        end
        do_reset();
        @(negedge clk);
        total++;
        if ({mreq, irdy, err} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL tmo_abort: got %b want 000", {mreq, irdy, err});
        end
`endif
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] mem_arbiter bench start");
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_traffic(1500, 60, 60, 50);
        test_traffic(400, 100, 100, 100);
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
